// File: rtl/fp32_mul_result_checker_pkg.sv
// fp32_chk_pkg: shared types and helpers for the FP32 multiplier result checker.
//   fp32_t       - IEEE-754 single-precision fields {sign, exp, mant}
//   fp_flags_t   - multiplier status flags {nan, inf, ovf, udf}
//   exp_entry_t  - one expectation as stored in the queue
//   is_nan / is_zero / ulp_diff - comparison helpers
package fp32_chk_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic ovf;
    logic udf;
  } fp_flags_t;

  typedef struct packed {
    fp_flags_t flags;
    fp32_t     value;
  } exp_entry_t;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.mant != '0);
  endfunction

  function automatic logic is_zero(input fp32_t x);
    return {x.exp, x.mant} == '0;
  endfunction

  // Distance in ULPs between two same-signed magnitudes.
  function automatic logic [31:0] ulp_diff(input fp32_t a, input fp32_t b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = {1'b0, a.exp, a.mant};
    mb = {1'b0, b.exp, b.mant};
    return (ma >= mb) ? (ma - mb) : (mb - ma);
  endfunction

endpackage

// File: rtl/fp32_mul_result_checker_if.sv
// fp32_mul_result_checker_if: expectation push channel (valid/ready).
//   exp_valid_i  - source offers an expectation
//   exp_ready_o  - checker queue can accept (not full)
//   exp_data_i   - expected FP32 bits
//   exp_flags_i  - expected {nan, inf, overflow, underflow}
// Modports: master = stimulus source, slave = checker.
interface fp32_mul_result_checker_if;
  import fp32_chk_pkg::*;

  logic      exp_valid_i;
  logic      exp_ready_o;
  fp32_t     exp_data_i;
  fp_flags_t exp_flags_i;

  modport master (output exp_valid_i, output exp_data_i, output exp_flags_i,
                  input  exp_ready_o);
  modport slave  (input  exp_valid_i, input  exp_data_i, input  exp_flags_i,
                  output exp_ready_o);
endinterface

// File: rtl/fp32_mul_result_checker_fifo.sv
// fp32_chk_fifo: synchronous FIFO holding pending expectations.
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   i_push/i_data - write one entry (caller guarantees !o_full)
//   i_pop         - drop head entry (caller guarantees !o_empty)
//   o_data        - current head entry (first-word fall-through)
//   o_full/o_empty/o_level - occupancy status
module fp32_chk_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
endmodule

// File: rtl/fp32_mul_result_checker.sv
// fp32_mul_result_checker: response-side checker for the FP32 multiplier.
// Pops one queued expectation per rising edge of done_i, compares it with
// product_i under a ULP tolerance and keeps saturating pass/error counts.
//   clk, rst         - rising-edge clock, synchronous active-high reset
//   exp              - expectation push channel (slave modport)
//   done_i           - multiplier completion (level or pulse)
//   product_i        - multiplier product bits
//   nan_i, inifinit_i, overflow_i, underflow_i - multiplier flags
//   clear_i          - clears counters and orphan_o; queue kept
//   pass_o / err_o   - one-cycle result pulses
//   orphan_o         - sticky: completion seen with empty queue
//   chk_count_o, err_count_o - saturating counters
//   last_bad_o, last_exp_o   - product/expected of latest compare failure
//   level_o          - queue occupancy
// Build option: define CHK_FLAGS_EN to also require flag equality.
module fp32_mul_result_checker
  import fp32_chk_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ULP_TOL = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fp32_mul_result_checker_if.slave   exp,
  input  logic                       done_i,
  input  logic [31:0]                product_i,
  input  logic                       nan_i,
  input  logic                       inifinit_i,
  input  logic                       overflow_i,
  input  logic                       underflow_i,
  input  logic                       clear_i,
  output logic                       pass_o,
  output logic                       err_o,
  output logic                       orphan_o,
  output logic [CNT_W-1:0]           chk_count_o,
  output logic [CNT_W-1:0]           err_count_o,
  output logic [31:0]                last_bad_o,
  output logic [31:0]                last_exp_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  exp_entry_t w_wr_entry;
  exp_entry_t w_head;
  logic       w_full, w_empty, w_push, w_pop, w_event;
  logic       r_done_q, r_rst_gate;

  logic       r_s1_valid, r_s1_orphan;
  fp32_t      r_s1_exp, r_s1_prod;
  fp_flags_t  r_s1_expf, r_s1_flags;

  logic       w_pass, w_flags_ok, w_nan_ok, w_fail, w_chk_inc;
  logic       r_pend_chk, r_pend_err, r_pend_orphan;
  logic [1:0] w_chk_add, w_err_add;

  assign w_wr_entry      = '{flags: exp.exp_flags_i, value: exp.exp_data_i};
  assign exp.exp_ready_o = !w_full;
  assign w_push          = exp.exp_valid_i && !w_full;
  // r_rst_gate blocks the first post-reset cycle so a held-high done_i
  // is absorbed into r_done_q instead of producing an event.
  assign w_event         = done_i && !r_done_q && !r_rst_gate;
  assign w_pop           = w_event && !w_empty;

  fp32_chk_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(exp_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

`ifdef CHK_FLAGS_EN
  assign w_flags_ok = (r_s1_flags == r_s1_expf);
  assign w_nan_ok   = r_s1_flags.nan;
`else
  logic w_unused_flags;
  assign w_flags_ok     = 1'b1;
  assign w_nan_ok       = 1'b1;
  assign w_unused_flags = ^{r_s1_flags, r_s1_expf};
`endif

  always_comb begin
    w_pass = 1'b0;
    if (is_nan(r_s1_exp))
      w_pass = is_nan(r_s1_prod) && w_nan_ok;
    else if (is_zero(r_s1_exp) && is_zero(r_s1_prod))
      w_pass = 1'b1;
    else
      w_pass = (r_s1_exp.sign == r_s1_prod.sign) &&
               (ulp_diff(r_s1_prod, r_s1_exp) <= ULP_TOL);
    w_pass = w_pass && w_flags_ok;
  end

  assign w_fail    = (r_s1_valid && !w_pass) || r_s1_orphan;
  assign w_chk_inc = r_s1_valid || r_s1_orphan;
  assign w_chk_add = {1'b0, r_pend_chk} + {1'b0, w_chk_inc};
  assign w_err_add = {1'b0, r_pend_err} + {1'b0, w_fail};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q      <= 1'b0;
      r_rst_gate    <= 1'b1;
      r_s1_valid    <= 1'b0;
      r_s1_orphan   <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_prod     <= '0;
      r_s1_expf     <= '0;
      r_s1_flags    <= '0;
      r_pend_chk    <= 1'b0;
      r_pend_err    <= 1'b0;
      r_pend_orphan <= 1'b0;
      pass_o        <= 1'b0;
      err_o         <= 1'b0;
      orphan_o      <= 1'b0;
      chk_count_o   <= '0;
      err_count_o   <= '0;
      last_bad_o    <= '0;
      last_exp_o    <= '0;
    end else begin
      r_done_q    <= done_i;
      r_rst_gate  <= 1'b0;
      r_s1_valid  <= w_pop;
      r_s1_orphan <= w_event && w_empty;
      if (w_pop) begin
        r_s1_exp   <= w_head.value;
        r_s1_expf  <= w_head.flags;
        r_s1_prod  <= product_i;
        r_s1_flags <= '{nan: nan_i, inf: inifinit_i, ovf: overflow_i, udf: underflow_i};
      end

      pass_o <= r_s1_valid && w_pass;
      err_o  <= w_fail;
      if (r_s1_valid && !w_pass) begin
        last_bad_o <= r_s1_prod;
        last_exp_o <= r_s1_exp;
      end

      // A clear wins its own cycle; the S1 result retiring in that cycle is
      // parked in r_pend_* and folded into the counters on the next edge.
      if (clear_i) begin
        chk_count_o   <= '0;
        err_count_o   <= '0;
        orphan_o      <= 1'b0;
        r_pend_chk    <= w_chk_inc;
        r_pend_err    <= w_fail;
        r_pend_orphan <= r_s1_orphan;
      end else begin
        chk_count_o   <= sat_add(chk_count_o, w_chk_add);
        err_count_o   <= sat_add(err_count_o, w_err_add);
        orphan_o      <= orphan_o || r_pend_orphan || r_s1_orphan;
        r_pend_chk    <= 1'b0;
        r_pend_err    <= 1'b0;
        r_pend_orphan <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp32_mul_result_checker.sv
// Directed bench for fp32_mul_result_checker. Two instances share stimulus:
// dut0 with ULP_TOL=0 and dut1 with ULP_TOL=1. Completions push expected
// outcomes into per-instance scoreboards; monitors pop on pass_o/err_o.
module tb_fp32_mul_result_checker;
  localparam logic [31:0] QNAN_V = fp32_chk_pkg::QNAN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, done_i, nan_i, inifinit_i, overflow_i, underflow_i, clear_i;
  logic [31:0] product_i;
  logic        tb_valid;
  logic [31:0] tb_data;
  logic [3:0]  tb_flags;

  fp32_mul_result_checker_if if0 ();
  fp32_mul_result_checker_if if1 ();
  assign if0.exp_valid_i = tb_valid;
  assign if0.exp_data_i  = tb_data;
  assign if0.exp_flags_i = tb_flags;
  assign if1.exp_valid_i = tb_valid;
  assign if1.exp_data_i  = tb_data;
  assign if1.exp_flags_i = tb_flags;

  logic        pass0, err0, orphan0, pass1, err1, orphan1;
  logic [15:0] chk0, errc0, chk1, errc1;
  logic [31:0] bad0, lexp0, bad1, lexp1;
  logic [3:0]  lvl0, lvl1;

  fp32_mul_result_checker #(.DEPTH(8), .ULP_TOL(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .exp(if0), .done_i(done_i), .product_i(product_i),
    .nan_i(nan_i), .inifinit_i(inifinit_i), .overflow_i(overflow_i),
    .underflow_i(underflow_i), .clear_i(clear_i), .pass_o(pass0), .err_o(err0),
    .orphan_o(orphan0), .chk_count_o(chk0), .err_count_o(errc0),
    .last_bad_o(bad0), .last_exp_o(lexp0), .level_o(lvl0));

  fp32_mul_result_checker #(.DEPTH(8), .ULP_TOL(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .exp(if1), .done_i(done_i), .product_i(product_i),
    .nan_i(nan_i), .inifinit_i(inifinit_i), .overflow_i(overflow_i),
    .underflow_i(underflow_i), .clear_i(clear_i), .pass_o(pass1), .err_o(err1),
    .orphan_o(orphan1), .chk_count_o(chk1), .err_count_o(errc1),
    .last_bad_o(bad1), .last_exp_o(lexp1), .level_o(lvl1));

  typedef struct {
    bit          pass;
    bit          orphan;
    logic [31:0] prod;
    logic [31:0] expd;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  sb_t e0, e1;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] f);
    tb_valid = 1'b1;
    tb_data  = d;
    tb_flags = f;
    step(1);
    tb_valid = 1'b0;
  endtask

  task automatic sb_add(input bit p0, input bit p1, input bit orph,
                        input logic [31:0] prod, input logic [31:0] expd);
    q0.push_back('{pass: p0, orphan: orph, prod: prod, expd: expd});
    q1.push_back('{pass: p1, orphan: orph, prod: prod, expd: expd});
  endtask

  // One completion: done high for one edge, low for the next.
  task automatic complete(input logic [31:0] prod, input logic [3:0] flg,
                          input bit p0, input bit p1, input logic [31:0] expd);
    sb_add(p0, p1, 1'b0, prod, expd);
    product_i = prod;
    {nan_i, inifinit_i, overflow_i, underflow_i} = flg;
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    if (!rst && (pass0 || err0)) begin
      if (q0.size() == 0) chk("dut0_unexpected_output", {pass0, err0}, 2'b00);
      else begin
        e0 = q0.pop_front();
        chk("dut0_result", {pass0, err0}, {e0.pass, !e0.pass});
        if (!e0.pass && !e0.orphan) begin
          chk("dut0_last_bad", bad0, e0.prod);
          chk("dut0_last_exp", lexp0, e0.expd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (pass1 || err1)) begin
      if (q1.size() == 0) chk("dut1_unexpected_output", {pass1, err1}, 2'b00);
      else begin
        e1 = q1.pop_front();
        chk("dut1_result", {pass1, err1}, {e1.pass, !e1.pass});
        if (!e1.pass && !e1.orphan) begin
          chk("dut1_last_bad", bad1, e1.prod);
          chk("dut1_last_exp", lexp1, e1.expd);
        end
      end
    end
  end

  logic [31:0] v [9];

  initial begin
    rst = 1'b1; done_i = 1'b0; product_i = '0; clear_i = 1'b0;
    {nan_i, inifinit_i, overflow_i, underflow_i} = '0;
    tb_valid = 1'b0; tb_data = '0; tb_flags = '0;
    for (int i = 0; i < 9; i++) v[i] = 32'h41000000 + i;
    step(3);
    rst = 1'b0;
    step(2);

    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_orphan", orphan0, 0);
    chk("rst_chk_count", chk0, 0);
    chk("rst_err_count", errc0, 0);
    chk("rst_ready", if0.exp_ready_o, 1);
    chk("rst_level", lvl0, 0);
    chk("rst_last_bad", bad0, 0);

    // exact match, pulse two edges after done is sampled
    push(32'h40400000, 4'b0000);
    complete(32'h40400000, 4'b0000, 1, 1, 32'h40400000);
    chk("exact_pass_latency", pass0, 1);
    chk("exact_chk_count", chk0, 1);
    chk("exact_err_count", errc0, 0);

    // one ULP off
    push(32'h3F800000, 4'b0000);
    complete(32'h3F800001, 4'b0000, 0, 1, 32'h3F800000);
    chk("ulp_err_tol0", err0, 1);
    chk("ulp_pass_tol1", pass1, 1);
    chk("ulp_last_bad", bad0, 32'h3F800001);
    chk("ulp_last_exp", lexp0, 32'h3F800000);
    chk("ulp_err_count_tol1", errc1, 0);

    // NaN, signed zero, sign mismatch, NaN vs Inf, Inf exact
    push(QNAN_V, 4'b1000);
    complete(32'h7FC00123, 4'b1000, 1, 1, QNAN_V);
    push(32'h00000000, 4'b0000);
    complete(32'h80000000, 4'b0000, 1, 1, 32'h00000000);
    push(32'h3F800000, 4'b0000);
    complete(32'hBF800000, 4'b0000, 0, 0, 32'h3F800000);
    push(QNAN_V, 4'b1000);
    complete(32'h7F800000, 4'b0100, 0, 0, QNAN_V);
    push(32'h7F800000, 4'b0100);
    complete(32'h7F800000, 4'b0100, 1, 1, 32'h7F800000);
    chk("special_chk_count", chk0, 7);
    chk("special_err_count_tol0", errc0, 3);
    chk("special_err_count_tol1", errc1, 2);

    // orphan with done held high for 5 cycles: exactly one event
    sb_add(0, 0, 1, 32'h12345678, 32'h0);
    product_i = 32'h12345678;
    {nan_i, inifinit_i, overflow_i, underflow_i} = '0;
    done_i = 1'b1;
    step(5);
    done_i = 1'b0;
    step(2);
    chk("orphan_sticky", orphan0, 1);
    chk("orphan_chk_count", chk0, 8);
    chk("orphan_err_count", errc0, 4);
    chk("orphan_keeps_last_bad", bad0, 32'h7F800000);

    // clear
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("clear_err_count", errc0, 0);
    chk("clear_chk_count", chk0, 0);
    chk("clear_orphan", orphan0, 0);
    chk("clear_err_count_tol1", errc1, 0);

    // clear while a result is in S1: counted on the following edge
    push(32'h40000000, 4'b0000);
    sb_add(1, 1, 0, 32'h40000000, 32'h40000000);
    product_i = 32'h40000000;
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("clear_priority_chk", chk0, 0);
    step(1);
    chk("clear_deferred_chk", chk0, 1);

    // fill the queue
    for (int i = 0; i < 8; i++) push(v[i], 4'b0000);
    chk("full_ready0", if0.exp_ready_o, 0);
    chk("full_ready1", if1.exp_ready_o, 0);
    chk("full_level", lvl0, 8);

    // pop while full with push offered: push refused, ready stays low this cycle
    tb_valid = 1'b1; tb_data = v[8]; tb_flags = '0;
    sb_add(1, 1, 0, v[0], v[0]);
    product_i = v[0];
    done_i = 1'b1;
    chk("full_ready_during_pop", if0.exp_ready_o, 0);
    step(1);
    done_i = 1'b0;
    tb_valid = 1'b0;
    chk("full_push_refused_level", lvl0, 7);
    chk("ready_after_pop", if0.exp_ready_o, 1);
    step(1);

    // push and pop in the same cycle
    tb_valid = 1'b1; tb_data = v[8];
    sb_add(1, 1, 0, v[1], v[1]);
    product_i = v[1];
    done_i = 1'b1;
    step(1);
    tb_valid = 1'b0;
    done_i = 1'b0;
    chk("push_pop_level", lvl0, 7);
    step(1);

    for (int i = 2; i < 9; i++) complete(v[i], 4'b0000, 1, 1, v[i]);
    chk("drain_level0", lvl0, 0);
    chk("drain_level1", lvl1, 0);
    chk("drain_chk_count", chk0, 10);
    chk("drain_err_count", errc0, 0);

    // reset mid-operation with done held high
    for (int i = 0; i < 3; i++) push(v[i], 4'b0000);
    rst = 1'b1;
    done_i = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    chk("rst2_level", lvl0, 0);
    chk("rst2_chk_count", chk0, 0);
    chk("rst2_err_count", errc0, 0);
    chk("rst2_orphan", orphan0, 0);
    chk("rst2_ready", if0.exp_ready_o, 1);
    done_i = 1'b0;
    step(1);
    sb_add(0, 0, 1, 32'h0, 32'h0);
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    step(2);
    chk("rst2_orphan_after_toggle", orphan0, 1);
    chk("rst2_err_count_after_toggle", errc0, 1);
    chk("rst2_err_count_tol1", errc1, 1);

    step(4);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
